// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_pkg
//  Description : Shared types for the tagged memory responder: bus command
//                encoding, pending-table entry layout, tag helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    // Number of usable tags; tag 0 is reserved to mean "none".
    localparam int N_TAGS = 15;
    localparam int TAG_W  = 4;

    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    // One pending-table slot. count is the remaining countdown before the
    // entry becomes ready (loads) or retires (stores).
    typedef struct packed {
        logic        valid;
        logic        is_load;
        logic [63:0] data;
        logic [3:0]  count;
    } MEM_PEND_ENTRY_t;

    // Population count of the entry valid bits.
    function automatic logic [3:0] count_valid(input logic [N_TAGS:1] v);
        logic [3:0] n;
        n = '0;
        for (int i = 1; i <= N_TAGS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_if
//  Description : Processor <-> memory request/response bundle.
//                master = processor side, slave = memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
    import mem_responder_pkg::*;

    bus_cmd_e    proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    tag_t        mem2proc_response;
    logic [63:0] mem2proc_data;
    tag_t        mem2proc_tag;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );

endinterface
`default_nettype wire

// File: rtl/mem_tag_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_tag_arbiter
//  Description : Combinational lowest-index priority picker over the 15 tag
//                request bits. Returns the winning tag, or 0 if none.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_tag_arbiter
    import mem_responder_pkg::*;
(
    input  logic [N_TAGS:1] req_i,
    output tag_t            tag_o
);

    // Scan downward so the last (lowest) requesting index wins.
    always_comb begin
        tag_o = '0;
        for (int i = N_TAGS; i >= 1; i--) begin
            if (req_i[i]) begin
                tag_o = TAG_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Tagged, fixed-latency memory model. Accepts one LOAD/STORE
//                per cycle onto the lowest free of 15 tags, returns load data
//                MEM_LATENCY cycles later on a registered tag/data broadcast.
//                Optional debug ports under MEM_RESPONDER_DEBUG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clock,
    input  logic              reset,
    mem_responder_if.slave    bus
`ifdef MEM_RESPONDER_DEBUG_EN
    ,
    output logic [N_TAGS:1]   pending_valid,
    output logic [3:0]        pending_count
`endif
);

    localparam int         AW          = $clog2(MEM_WORDS);
    // Loads: count starts so the entry is ready in the cycle before its
    // broadcast, letting the registered output land exactly at T+MEM_LATENCY.
    localparam logic [3:0] LOAD_COUNT  = 4'(MEM_LATENCY - 2);
    // Stores: held valid for MEM_LATENCY cycles after the accept cycle.
    localparam logic [3:0] STORE_COUNT = 4'(MEM_LATENCY - 1);

    logic [63:0]     mem_q  [MEM_WORDS];
    MEM_PEND_ENTRY_t pend_q [1:N_TAGS];
    MEM_PEND_ENTRY_t pend_d [1:N_TAGS];

    logic [N_TAGS:1] free_w;
    logic [N_TAGS:1] ready_w;
    tag_t            alloc_tag_w;
    tag_t            done_tag_w;
    tag_t            tag_q, tag_d;
    logic [63:0]     data_q, data_d;
    logic [AW-1:0]   word_w;
    logic            is_req_w;
    logic            is_store_w;
    logic            accept_w;
    logic            unused_addr_w;

    assign word_w        = bus.proc2mem_addr[3 +: AW];
    assign unused_addr_w = ^{bus.proc2mem_addr[63:3+AW], bus.proc2mem_addr[2:0]};
    assign is_store_w    = (bus.proc2mem_command == BUS_STORE);
    assign is_req_w      = (bus.proc2mem_command == BUS_LOAD) || is_store_w;
    assign accept_w      = !reset && is_req_w && (alloc_tag_w != '0);

    // Per-tag free/ready status, derived only from registered state. The tag
    // currently on the broadcast register is excluded from the ready set.
    for (genvar g = 1; g <= N_TAGS; g++) begin : g_status
        assign free_w[g]  = !pend_q[g].valid;
        assign ready_w[g] = pend_q[g].valid && pend_q[g].is_load &&
                            (pend_q[g].count == 4'd0) && (tag_q != TAG_W'(g));
    end

    mem_tag_arbiter u_alloc_arb (
        .req_i (free_w),
        .tag_o (alloc_tag_w)
    );

    mem_tag_arbiter u_done_arb (
        .req_i (ready_w),
        .tag_o (done_tag_w)
    );

    assign bus.mem2proc_response = accept_w ? alloc_tag_w : '0;
    assign bus.mem2proc_tag      = tag_q;
    assign bus.mem2proc_data     = data_q;

    // Next state for the pending table and broadcast register.
    always_comb begin
        pend_d = pend_q;
        tag_d  = done_tag_w;
        data_d = '0;
        for (int i = 1; i <= N_TAGS; i++) begin
            if (done_tag_w == TAG_W'(i)) begin
                data_d = pend_q[i].data;
            end
            if (pend_q[i].valid) begin
                if (pend_q[i].is_load) begin
                    if (tag_q == TAG_W'(i)) begin
                        pend_d[i] = '0;
                    end else if (pend_q[i].count != 4'd0) begin
                        pend_d[i].count = pend_q[i].count - 4'd1;
                    end
                end else begin
                    if (pend_q[i].count == 4'd0) begin
                        pend_d[i] = '0;
                    end else begin
                        pend_d[i].count = pend_q[i].count - 4'd1;
                    end
                end
            end
            // Allocation only ever targets a free slot, so it never collides
            // with the retire/countdown updates above.
            if (accept_w && (alloc_tag_w == TAG_W'(i))) begin
                pend_d[i].valid   = 1'b1;
                pend_d[i].is_load = !is_store_w;
                pend_d[i].data    = is_store_w ? 64'd0 : mem_q[word_w];
                pend_d[i].count   = is_store_w ? STORE_COUNT : LOAD_COUNT;
            end
        end
    end

    // Pending table and broadcast register; cleared on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i <= N_TAGS; i++) begin
                pend_q[i] <= '0;
            end
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

    // Backing store write; contents survive reset.
    always_ff @(posedge clock) begin
        if (accept_w && is_store_w) begin
            mem_q[word_w] <= bus.proc2mem_data;
        end
    end

`ifdef MEM_RESPONDER_DEBUG_EN
    assign pending_valid = ~free_w;
    assign pending_count = count_valid(~free_w);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Directed self-checking bench. Instance A uses the default
//                latency of 4; instance B uses latency 15 so all 15 tags can
//                be held busy at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
    import mem_responder_pkg::*;

    typedef struct {
        bus_cmd_e    cmd;
        logic [63:0] addr;
        logic [63:0] wdata;
        tag_t        resp;
        tag_t        tag;
        logic [63:0] rdata;
    } vec_t;

    localparam logic [63:0] D1 = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] D2 = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] D3 = 64'hA5A5_0F0F_C3C3_7E7E;
    localparam logic [63:0] D4 = 64'h0BAD_F00D_CAFE_0001;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_responder_if bus_a();
    mem_responder_if bus_b();

`ifdef MEM_RESPONDER_DEBUG_EN
    logic [15:1] dbg_valid_a, dbg_valid_b;
    logic [3:0]  dbg_count_a, dbg_count_b;
`endif

    mem_responder #(.MEM_WORDS(1024), .MEM_LATENCY(4)) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_a)
`ifdef MEM_RESPONDER_DEBUG_EN
        ,
        .pending_valid (dbg_valid_a),
        .pending_count (dbg_count_a)
`endif
    );

    mem_responder #(.MEM_WORDS(1024), .MEM_LATENCY(15)) u_dut_deep (
        .clock (clk),
        .reset (rst),
        .bus   (bus_b)
`ifdef MEM_RESPONDER_DEBUG_EN
        ,
        .pending_valid (dbg_valid_b),
        .pending_count (dbg_count_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.proc2mem_command = BUS_NONE;
        bus_b.proc2mem_command = BUS_NONE;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        bus_a.proc2mem_command = BUS_LOAD;
        bus_b.proc2mem_command = BUS_LOAD;
        @(negedge clk);
        checks++;
        if (bus_a.mem2proc_response !== 4'd0) begin
            errors++; $display("FAIL reset_resp_a got %0d want 0", bus_a.mem2proc_response);
        end
        checks++;
        if (bus_b.mem2proc_response !== 4'd0) begin
            errors++; $display("FAIL reset_resp_b got %0d want 0", bus_b.mem2proc_response);
        end
        checks++;
        if (bus_a.mem2proc_tag !== 4'd0 || bus_a.mem2proc_data !== 64'd0) begin
            errors++; $display("FAIL reset_out_a tag %0d data %h want 0/0", bus_a.mem2proc_tag, bus_a.mem2proc_data);
        end
        checks++;
        if (bus_b.mem2proc_tag !== 4'd0 || bus_b.mem2proc_data !== 64'd0) begin
            errors++; $display("FAIL reset_out_b tag %0d data %h want 0/0", bus_b.mem2proc_tag, bus_b.mem2proc_data);
        end
        tick();
        bus_a.proc2mem_command = BUS_NONE;
        bus_b.proc2mem_command = BUS_NONE;
        rst = 1'b0;
        tick();
    endtask

    // Store then load the same word; a load issued while the store still
    // holds tag 1 gets tag 2, and stores never show up on the broadcast.
    task automatic test_store_load();
        vec_t v [11];
        v[0]  = '{BUS_STORE, 64'h40, D1,    4'd1, 4'd0, 64'd0};
        v[1]  = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd0, 64'd0};
        v[2]  = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd0, 64'd0};
        v[3]  = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd0, 64'd0};
        v[4]  = '{BUS_LOAD,  64'h40, 64'd0, 4'd2, 4'd0, 64'd0};
        v[5]  = '{BUS_LOAD,  64'h40, 64'd0, 4'd1, 4'd0, 64'd0};
        v[6]  = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd0, 64'd0};
        v[7]  = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd0, 64'd0};
        v[8]  = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd2, D1};
        v[9]  = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd1, D1};
        v[10] = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd0, 64'd0};
        for (int i = 0; i < 11; i++) begin
            bus_a.proc2mem_command = v[i].cmd;
            bus_a.proc2mem_addr    = v[i].addr;
            bus_a.proc2mem_data    = v[i].wdata;
            @(negedge clk);
            checks++;
            if (bus_a.mem2proc_response !== v[i].resp) begin
                errors++; $display("FAIL store_load[%0d] response got %0d want %0d", i, bus_a.mem2proc_response, v[i].resp);
            end
            checks++;
            if (bus_a.mem2proc_tag !== v[i].tag) begin
                errors++; $display("FAIL store_load[%0d] tag got %0d want %0d", i, bus_a.mem2proc_tag, v[i].tag);
            end
            checks++;
            if (bus_a.mem2proc_data !== v[i].rdata) begin
                errors++; $display("FAIL store_load[%0d] data got %h want %h", i, bus_a.mem2proc_data, v[i].rdata);
            end
            tick();
        end
        bus_a.proc2mem_command = BUS_NONE;
    endtask

    // Back-to-back loads on tags 2 and 3 broadcast on consecutive cycles,
    // with new requests accepted in the same cycles as broadcasts.
    task automatic test_back_to_back();
        vec_t v [12];
        v[0]  = '{BUS_STORE, 64'h48, D2,    4'd1, 4'd0, 64'd0};
        v[1]  = '{BUS_LOAD,  64'h40, 64'd0, 4'd2, 4'd0, 64'd0};
        v[2]  = '{BUS_LOAD,  64'h48, 64'd0, 4'd3, 4'd0, 64'd0};
        v[3]  = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd0, 64'd0};
        v[4]  = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd0, 64'd0};
        v[5]  = '{BUS_STORE, 64'h50, D3,    4'd1, 4'd2, D1};
        v[6]  = '{BUS_LOAD,  64'h50, 64'd0, 4'd2, 4'd3, D2};
        v[7]  = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd0, 64'd0};
        v[8]  = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd0, 64'd0};
        v[9]  = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd0, 64'd0};
        v[10] = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd2, D3};
        v[11] = '{BUS_NONE,  64'h0,  64'd0, 4'd0, 4'd0, 64'd0};
        for (int i = 0; i < 12; i++) begin
            bus_a.proc2mem_command = v[i].cmd;
            bus_a.proc2mem_addr    = v[i].addr;
            bus_a.proc2mem_data    = v[i].wdata;
            @(negedge clk);
            checks++;
            if (bus_a.mem2proc_response !== v[i].resp) begin
                errors++; $display("FAIL back_to_back[%0d] response got %0d want %0d", i, bus_a.mem2proc_response, v[i].resp);
            end
            checks++;
            if (bus_a.mem2proc_tag !== v[i].tag) begin
                errors++; $display("FAIL back_to_back[%0d] tag got %0d want %0d", i, bus_a.mem2proc_tag, v[i].tag);
            end
            checks++;
            if (bus_a.mem2proc_data !== v[i].rdata) begin
                errors++; $display("FAIL back_to_back[%0d] data got %h want %h", i, bus_a.mem2proc_data, v[i].rdata);
            end
            tick();
        end
        bus_a.proc2mem_command = BUS_NONE;
    endtask

    // Address 0 and MEM_WORDS*8 alias the same word.
    task automatic test_wrap();
        vec_t v [8];
        v[0] = '{BUS_STORE, 64'h0,    D4,    4'd1, 4'd0, 64'd0};
        v[1] = '{BUS_LOAD,  64'h0,    64'd0, 4'd2, 4'd0, 64'd0};
        v[2] = '{BUS_LOAD,  64'h2000, 64'd0, 4'd3, 4'd0, 64'd0};
        v[3] = '{BUS_NONE,  64'h0,    64'd0, 4'd0, 4'd0, 64'd0};
        v[4] = '{BUS_NONE,  64'h0,    64'd0, 4'd0, 4'd0, 64'd0};
        v[5] = '{BUS_NONE,  64'h0,    64'd0, 4'd0, 4'd2, D4};
        v[6] = '{BUS_NONE,  64'h0,    64'd0, 4'd0, 4'd3, D4};
        v[7] = '{BUS_NONE,  64'h0,    64'd0, 4'd0, 4'd0, 64'd0};
        for (int i = 0; i < 8; i++) begin
            bus_a.proc2mem_command = v[i].cmd;
            bus_a.proc2mem_addr    = v[i].addr;
            bus_a.proc2mem_data    = v[i].wdata;
            @(negedge clk);
            checks++;
            if (bus_a.mem2proc_response !== v[i].resp) begin
                errors++; $display("FAIL wrap[%0d] response got %0d want %0d", i, bus_a.mem2proc_response, v[i].resp);
            end
            checks++;
            if (bus_a.mem2proc_tag !== v[i].tag) begin
                errors++; $display("FAIL wrap[%0d] tag got %0d want %0d", i, bus_a.mem2proc_tag, v[i].tag);
            end
            checks++;
            if (bus_a.mem2proc_data !== v[i].rdata) begin
                errors++; $display("FAIL wrap[%0d] data got %h want %h", i, bus_a.mem2proc_data, v[i].rdata);
            end
            tick();
        end
        bus_a.proc2mem_command = BUS_NONE;
    endtask

    // Reset with five loads in flight: nothing stale afterwards, tags restart
    // at 1, and the backing store keeps its contents.
    task automatic test_reset_midflight();
        for (int i = 0; i < 5; i++) begin
            bus_a.proc2mem_command = BUS_LOAD;
            bus_a.proc2mem_addr    = 64'h40;
            @(negedge clk);
            checks++;
            if (bus_a.mem2proc_response !== 4'(i + 1)) begin
                errors++; $display("FAIL midflight_issue[%0d] response got %0d want %0d", i, bus_a.mem2proc_response, i + 1);
            end
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.mem2proc_response !== 4'd0) begin
            errors++; $display("FAIL midflight_reset_resp got %0d want 0", bus_a.mem2proc_response);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus_a.mem2proc_tag !== 4'd0 || bus_a.mem2proc_data !== 64'd0) begin
            errors++; $display("FAIL midflight_reset_out tag %0d data %h want 0/0", bus_a.mem2proc_tag, bus_a.mem2proc_data);
        end
        tick();
        rst = 1'b0;
        bus_a.proc2mem_command = BUS_NONE;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (bus_a.mem2proc_tag !== 4'd0) begin
                errors++; $display("FAIL midflight_stale[%0d] tag got %0d want 0", i, bus_a.mem2proc_tag);
            end
            tick();
        end
        bus_a.proc2mem_command = BUS_LOAD;
        bus_a.proc2mem_addr    = 64'h40;
        @(negedge clk);
        checks++;
        if (bus_a.mem2proc_response !== 4'd1) begin
            errors++; $display("FAIL midflight_next response got %0d want 1", bus_a.mem2proc_response);
        end
        tick();
        bus_a.proc2mem_command = BUS_NONE;
        tick();
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (bus_a.mem2proc_tag !== 4'd1 || bus_a.mem2proc_data !== D1) begin
            errors++; $display("FAIL midflight_keep tag %0d data %h want 1/%h", bus_a.mem2proc_tag, bus_a.mem2proc_data, D1);
        end
        tick();
    endtask

    // Fifteen loads fill every tag; the sixteenth is rejected and disturbs
    // nothing (latency-15 instance).
    task automatic test_full_table();
        do_reset();
        bus_b.proc2mem_addr = 64'h0;
        bus_b.proc2mem_data = 64'd0;
        for (int c = 0; c < 18; c++) begin
            bus_b.proc2mem_command = (c < 17) ? BUS_LOAD : BUS_NONE;
            @(negedge clk);
            if (c < 15) begin
                checks++;
                if (bus_b.mem2proc_response !== 4'(c + 1)) begin
                    errors++; $display("FAIL full[%0d] response got %0d want %0d", c, bus_b.mem2proc_response, c + 1);
                end
            end else if (c == 15) begin
                checks++;
                if (bus_b.mem2proc_response !== 4'd0) begin
                    errors++; $display("FAIL full_reject response got %0d want 0", bus_b.mem2proc_response);
                end
                checks++;
                if (bus_b.mem2proc_tag !== 4'd1) begin
                    errors++; $display("FAIL full_bcast1 tag got %0d want 1", bus_b.mem2proc_tag);
                end
            end else if (c == 16) begin
                checks++;
                if (bus_b.mem2proc_response !== 4'd1) begin
                    errors++; $display("FAIL full_reissue response got %0d want 1", bus_b.mem2proc_response);
                end
                checks++;
                if (bus_b.mem2proc_tag !== 4'd2) begin
                    errors++; $display("FAIL full_bcast2 tag got %0d want 2", bus_b.mem2proc_tag);
                end
            end else begin
                checks++;
                if (bus_b.mem2proc_tag !== 4'd3) begin
                    errors++; $display("FAIL full_bcast3 tag got %0d want 3", bus_b.mem2proc_tag);
                end
            end
            tick();
        end
        bus_b.proc2mem_command = BUS_NONE;
    endtask

    // Tag 3 retires in cycle 18 while every other tag is busy: a load there
    // is rejected, and the load one cycle later gets tag 3.
    task automatic test_retire_race();
        tag_t exp_resp [20];
        do_reset();
        exp_resp[0] = 4'd1;
        exp_resp[1] = 4'd2;
        exp_resp[2] = 4'd0;
        for (int c = 3; c <= 15; c++) exp_resp[c] = 4'(c);
        exp_resp[16] = 4'd1;
        exp_resp[17] = 4'd2;
        exp_resp[18] = 4'd0;
        exp_resp[19] = 4'd3;
        bus_b.proc2mem_addr = 64'h8;
        for (int c = 0; c < 20; c++) begin
            bus_b.proc2mem_command = (c == 2) ? BUS_NONE : BUS_LOAD;
            @(negedge clk);
            checks++;
            if (bus_b.mem2proc_response !== exp_resp[c]) begin
                errors++; $display("FAIL retire_race[%0d] response got %0d want %0d", c, bus_b.mem2proc_response, exp_resp[c]);
            end
            if (c == 18) begin
                checks++;
                if (bus_b.mem2proc_tag !== 4'd3) begin
                    errors++; $display("FAIL retire_race_bcast tag got %0d want 3", bus_b.mem2proc_tag);
                end
            end
            tick();
        end
        bus_b.proc2mem_command = BUS_NONE;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_a.proc2mem_command = BUS_NONE;
        bus_a.proc2mem_addr    = 64'd0;
        bus_a.proc2mem_data    = 64'd0;
        bus_b.proc2mem_command = BUS_NONE;
        bus_b.proc2mem_addr    = 64'd0;
        bus_b.proc2mem_data    = 64'd0;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_wrap();
        test_reset_midflight();
        test_full_table();
        test_retire_race();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, giving the backing-store depth in 64-bit words (power of two).
REQ-002 SHALL have parameter MEM_LATENCY, default 4, giving the uncontended accept-to-data latency in cycles (legal range 2..15).
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 proc2mem_command  input  2  BUS_NONE / BUS_LOAD / BUS_STORE.
REQ-006 proc2mem_addr  input  64  byte address; word index = addr[3+$clog2(MEM_WORDS)-1:3], upper bits ignored (wrap modulo MEM_WORDS).
REQ-007 proc2mem_data  input  64  store data.
REQ-008 mem2proc_response  output  4  combinational; nonzero = request accepted with this tag; 0 = rejected.
REQ-009 mem2proc_data  output  64  registered load data.
REQ-010 mem2proc_tag  output  4  registered; nonzero = mem2proc_data belongs to that tag.

Function
REQ-011 SHALL keep a 15-entry pending table indexed by tags 1..15; each entry holds valid, is_load, 64-bit snapshot data and a countdown.
REQ-012 SHALL, when the command is LOAD or STORE and any entry is free, drive mem2proc_response = lowest free tag in the same cycle; otherwise drive 0.
REQ-013 SHALL drive mem2proc_response = 0 for BUS_NONE.
REQ-014 SHALL compute free status from registered valid bits only; a tag retiring in cycle T is not reissued before cycle T+1.
REQ-015 SHALL, for a rejected request, change no state (no write, no allocation).
REQ-016 SHALL, on an accepted LOAD in cycle T, snapshot mem[word] at the edge ending T, including a STORE to the same word accepted in an earlier cycle.
REQ-017 SHALL, on an accepted STORE in cycle T, write proc2mem_data to mem[word] at the edge ending T; the store occupies its tag for MEM_LATENCY cycles, then retires silently (never appears on mem2proc_tag).
REQ-018 SHALL present an uncontended load's tag and data on mem2proc_tag/mem2proc_data in cycle T+MEM_LATENCY, for exactly one cycle, and free the entry at the end of that cycle.
REQ-019 SHALL, when several loads are ready in one cycle, broadcast the lowest tag; the others stay ready and are broadcast in later cycles in ascending tag order.
REQ-020 SHALL drive mem2proc_tag = 0 and mem2proc_data = 0 in any cycle with no broadcast.
REQ-021 SHALL accept a new request and broadcast a completion in the same cycle without interference.

Reset
REQ-022 SHALL, while reset is high, clear all pending entries and registered outputs to 0; mem2proc_response SHALL be 0.
REQ-023 SHALL drop in-flight requests on reset mid-operation; no stale tag SHALL appear after reset deasserts.
REQ-024 SHALL NOT clear the backing-store contents on reset.

Configuration
REQ-025 With MEM_RESPONDER_DEBUG_EN defined, SHALL add output ports pending_valid[15:1] (entry valid bits) and pending_count[3:0] (popcount of valid entries); without it those ports SHALL NOT exist and behaviour is otherwise identical.

Structure
REQ-026 SHALL take the BUS_NONE/BUS_LOAD/BUS_STORE command encoding and the MEM_PEND_ENTRY_t struct (valid, is_load, data, count) from the shared package.
REQ-027 SHALL instantiate one sub-module, mem_tag_arbiter: a combinational lowest-index priority picker over 15 request bits, used for both free-tag allocation and completion selection.

Verification
REQ-028 After reset, STORE 0xDEAD_BEEF to addr 0x40, then LOAD 0x40 in cycle T -> response 1 in cycle T (tag 1 freed from the store), mem2proc_tag = 1 with data 0xDEAD_BEEF in cycle T+4, and 0 in T+5.
REQ-029 Issue 15 back-to-back LOADs, then a 16th -> responses 1..15, then 0 for the 16th; the table is unchanged by the rejection.
REQ-030 Accept LOADs on tags 1 and 2 in the same-latency window so both are ready in one cycle -> tag 1 broadcast first, tag 2 one cycle later.
REQ-031 Tag 3 retires in cycle T while a LOAD is issued in T with all other tags busy -> response 0 in T; a LOAD in T+1 gets response 3.
REQ-032 Assert reset with 5 loads in flight -> no nonzero mem2proc_tag after reset deasserts; the next LOAD gets tag 1.
REQ-033 LOAD addresses 0x0 and MEM_WORDS*8 -> both return the same word (wrap-around).
